// File: rtl/psram_fb_sched.sv
// psram_fb_sched: per-line read-burst / write-FIFO slot scheduler for a 2-channel PSRAM framebuffer.
// Optional build macro PSRAM_SCHED_STATS_EN adds saturating drop_cnt/abort_cnt outputs.
module psram_fb_sched #(
    parameter int SLOT        = 32,
    parameter int RD_BURSTS   = 6,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        calib_done,
    input  logic        line_start,
    input  logic [8:0]  line_num,
    input  logic [2:0]  page,
    input  logic        wr_req,
    output logic        wr_ready,
    input  logic [17:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        cmd0,
    output logic        cmd_en0,
    output logic [20:0] addr0,
    output logic [31:0] wr_data0,
    output logic [3:0]  data_mask0,
    output logic        cmd1,
    output logic        cmd_en1,
    output logic [20:0] addr1,
    output logic [31:0] wr_data1,
    output logic [3:0]  data_mask1,
`ifdef PSRAM_SCHED_STATS_EN
    output logic [15:0] drop_cnt,
    output logic [15:0] abort_cnt,
`endif
    output logic        rd_phase
);
    localparam int TW = $clog2(SLOT);
    localparam int AW = $clog2(WFIFO_DEPTH);
    localparam logic [1:0] WAIT_CAL = 2'd0, IDLE = 2'd1, READ = 2'd2, WRITE = 2'd3;

    logic [1:0]    state;
    logic [TW-1:0] timer;
    logic          ch;
    logic [2:0]    k;
    logic [8:0]    line_q;
    logic [2:0]    page_q;
    logic [17:0]   fa [WFIFO_DEPTH];
    logic [31:0]   fd [WFIFO_DEPTH];
    logic [2:0]    fp [WFIFO_DEPTH];
    logic [AW-1:0] rp, wp;
    logic [AW:0]   cnt, cnt_next;
    logic          start, slot, rd_go, wr_go, go, last_rd, push, full;
    logic [20:0]   cmd_addr;

    // A new line restarts the schedule and suppresses whatever slot coincides with it.
    assign start    = calib_done && line_start && state != WAIT_CAL;
    assign slot     = calib_done && timer == '0 && !start;
    assign rd_go    = slot && state == READ;
    assign wr_go    = slot && state == WRITE && cnt != '0 && fa[rp][5] == ch;
    assign go       = rd_go || wr_go;
    assign last_rd  = rd_go && ch && k == 3'(RD_BURSTS - 1);
    assign full     = cnt == (AW+1)'(WFIFO_DEPTH);
    assign push     = wr_req && (!full || wr_go);
    assign cnt_next = cnt + (AW+1)'(push) - (AW+1)'(wr_go);
    assign cmd_addr = wr_go ? {fp[rp], fa[rp][17:6], fa[rp][4:0], 1'b0} : {page_q, line_q, k, 6'b0};

    // Slot timer, channel toggle and line/burst state machine.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= WAIT_CAL;
            timer  <= '0;
            ch     <= 1'b0;
            k      <= '0;
            line_q <= '0;
            page_q <= '0;
        end else if (!calib_done) begin
            state <= WAIT_CAL;
        end else if (start) begin
            state  <= READ;
            timer  <= '0;
            ch     <= 1'b0;
            k      <= '0;
            line_q <= line_num;
            page_q <= page;
        end else begin
            timer <= timer == TW'(SLOT - 1) ? '0 : timer + 1'b1;
            if (timer == TW'(SLOT - 1)) ch <= ~ch;
            if (state == WAIT_CAL) state <= IDLE;
            if (last_rd) state <= WRITE;
            else if (rd_go && ch) k <= k + 1'b1;
        end
    end

    // Write FIFO storage; each entry keeps the page that was current when it was pushed.
    always_ff @(posedge clk) begin
        if (push) begin
            fa[wp] <= wr_addr;
            fd[wp] <= wr_data;
            fp[wp] <= page;
        end
    end

    // FIFO pointers and occupancy; a pop frees room for a same-cycle push when full.
    always_ff @(posedge clk) begin
        if (reset) begin
            rp       <= '0;
            wp       <= '0;
            cnt      <= '0;
            wr_ready <= 1'b1;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (wr_go) rp <= rp + 1'b1;
            cnt      <= cnt_next;
            wr_ready <= cnt_next != (AW+1)'(WFIFO_DEPTH);
        end
    end

    // Registered command outputs; only the channel owning the current slot strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd0       <= 1'b0;
            cmd_en0    <= 1'b0;
            addr0      <= '0;
            wr_data0   <= '0;
            data_mask0 <= 4'hF;
            cmd1       <= 1'b0;
            cmd_en1    <= 1'b0;
            addr1      <= '0;
            wr_data1   <= '0;
            data_mask1 <= 4'hF;
            rd_phase   <= 1'b0;
        end else begin
            cmd_en0    <= go && !ch;
            cmd_en1    <= go && ch;
            data_mask0 <= wr_go && !ch ? 4'h0 : 4'hF;
            data_mask1 <= wr_go && ch ? 4'h0 : 4'hF;
            rd_phase   <= calib_done && (start || (state == READ && !last_rd));
            if (go && !ch) begin
                cmd0  <= wr_go;
                addr0 <= cmd_addr;
                if (wr_go) wr_data0 <= fd[rp];
            end
            if (go && ch) begin
                cmd1  <= wr_go;
                addr1 <= cmd_addr;
                if (wr_go) wr_data1 <= fd[rp];
            end
        end
    end

`ifdef PSRAM_SCHED_STATS_EN
    // Saturating counters for refused writes and aborted read sequences.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt  <= '0;
            abort_cnt <= '0;
        end else begin
            if (wr_req && !push && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
            if (start && state == READ && abort_cnt != 16'hFFFF) abort_cnt <= abort_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_psram_fb_sched.sv
// tb_psram_fb_sched: directed, table-driven checks of the PSRAM framebuffer slot scheduler.
module tb_psram_fb_sched;
    logic        clk = 0, reset = 1, calib_done = 0, line_start = 0, wr_req = 0;
    logic [8:0]  line_num = 0;
    logic [2:0]  page = 0;
    logic [17:0] wr_addr = 0;
    logic [31:0] wr_data = 0;
    logic        wr_ready, cmd0, cmd_en0, cmd1, cmd_en1, rd_phase;
    logic [20:0] addr0, addr1;
    logic [31:0] wr_data0, wr_data1;
    logic [3:0]  data_mask0, data_mask1;
`ifdef PSRAM_SCHED_STATS_EN
    logic [15:0] drop_cnt, abort_cnt;
`endif

    psram_fb_sched dut (
        .clk(clk), .reset(reset), .calib_done(calib_done), .line_start(line_start),
        .line_num(line_num), .page(page), .wr_req(wr_req), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .cmd0(cmd0), .cmd_en0(cmd_en0), .addr0(addr0), .wr_data0(wr_data0), .data_mask0(data_mask0),
        .cmd1(cmd1), .cmd_en1(cmd_en1), .addr1(addr1), .wr_data1(wr_data1), .data_mask1(data_mask1),
`ifdef PSRAM_SCHED_STATS_EN
        .drop_cnt(drop_cnt), .abort_cnt(abort_cnt),
`endif
        .rd_phase(rd_phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          t;
        logic        ch;
        logic        cmd;
        logic [20:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } ev_t;

    ev_t log_q[$];
    ev_t exp_q[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cmd_en0) log_q.push_back('{cyc, 1'b0, cmd0, addr0, wr_data0, data_mask0});
        if (cmd_en1) log_q.push_back('{cyc, 1'b1, cmd1, addr1, wr_data1, data_mask1});
        if (cmd_en0 && cmd_en1) begin
            errors++;
            $display("FAIL dual_strobe at cycle %0d", cyc);
        end
    end

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic add_rd(input int t, input logic c, input logic [20:0] a);
        exp_q.push_back('{t, c, 1'b0, a, 32'h0, 4'hF});
    endtask

    task automatic add_wr(input int t, input logic c, input logic [20:0] a, input logic [31:0] d);
        exp_q.push_back('{t, c, 1'b1, a, d, 4'h0});
    endtask

    task automatic clear_q();
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic pulse_line(input logic [8:0] ln, input logic [2:0] pg, output int t0);
        line_num   = ln;
        page       = pg;
        line_start = 1;
        t0         = cyc;
        @(negedge clk);
        line_start = 0;
    endtask

    task automatic push(input logic [17:0] a, input logic [31:0] d, input logic [2:0] pg);
        wr_addr = a;
        wr_data = d;
        page    = pg;
        wr_req  = 1;
        @(negedge clk);
        wr_req  = 0;
    endtask

    task automatic cmp_log(input string n);
        chk($sformatf("%s.count", n), 64'(log_q.size()), 64'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < log_q.size()) begin
                chk($sformatf("%s[%0d].cycle", n, i), 64'(log_q[i].t), 64'(exp_q[i].t));
                chk($sformatf("%s[%0d].ch", n, i), 64'(log_q[i].ch), 64'(exp_q[i].ch));
                chk($sformatf("%s[%0d].cmd", n, i), 64'(log_q[i].cmd), 64'(exp_q[i].cmd));
                chk($sformatf("%s[%0d].addr", n, i), 64'(log_q[i].addr), 64'(exp_q[i].addr));
                chk($sformatf("%s[%0d].mask", n, i), 64'(log_q[i].mask), 64'(exp_q[i].mask));
                if (exp_q[i].cmd) chk($sformatf("%s[%0d].data", n, i), 64'(log_q[i].data), 64'(exp_q[i].data));
            end
        end
    endtask

    initial begin
        int t0, t1, tw;
        logic [17:0] wa [5];
        logic [31:0] wd [5];
        logic [20:0] wx [4];
        wa = '{18'h00100, 18'h00120, 18'h00140, 18'h3FFE5, 18'h00000};
        wd = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
        wx = '{21'h040100, 21'h040100, 21'h040140, 21'h07FFCA};

        tick(3);
        chk("rst.cmd_en0", 64'(cmd_en0), 0);
        chk("rst.cmd_en1", 64'(cmd_en1), 0);
        chk("rst.cmd0", 64'(cmd0), 0);
        chk("rst.addr1", 64'(addr1), 0);
        chk("rst.wr_data0", 64'(wr_data0), 0);
        chk("rst.mask0", 64'(data_mask0), 64'hF);
        chk("rst.mask1", 64'(data_mask1), 64'hF);
        chk("rst.rd_phase", 64'(rd_phase), 0);
        chk("rst.wr_ready", 64'(wr_ready), 1);
        reset = 0;

        for (int i = 0; i < 10; i++) begin
            pulse_line(9'(i), 3'd2, t0);
            tick(20);
        end
        chk("nocal.strobes", 64'(log_q.size()), 0);
        chk("nocal.rd_phase", 64'(rd_phase), 0);

        calib_done = 1;
        tick(3);
        clear_q();
        pulse_line(9'd5, 3'd2, t0);
        chk("rd.rd_phase_hi", 64'(rd_phase), 1);
        for (int i = 0; i < 12; i++) add_rd(t0 + 2 + 32 * i, i[0], 21'h080A00 + 21'((i / 2) * 64));
        tick(12 * 32 + 10);
        chk("rd.rd_phase_lo", 64'(rd_phase), 0);
        cmp_log("rd");

        clear_q();
        tw = t0 + 2 + 32;
        while (tw < cyc + 2) tw += 64;
        push(18'h00020, 32'hA5A5F00F, 3'd2);
        add_wr(tw, 1'b1, 21'h080000, 32'hA5A5F00F);
        tick(150);
        cmp_log("wr1");

        calib_done = 0;
        tick(2);
        clear_q();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fill.ready%0d", i), 64'(wr_ready), 1);
            push(wa[i], wd[i], 3'd1);
        end
        chk("fill.full", 64'(wr_ready), 0);
        push(wa[4], wd[4], 3'd1);
        chk("fill.still_full", 64'(wr_ready), 0);
        calib_done = 1;
        tick(3);
        pulse_line(9'd7, 3'd1, t0);
        for (int i = 0; i < 12; i++) add_rd(t0 + 2 + 32 * i, i[0], 21'h040E00 + 21'((i / 2) * 64));
        for (int j = 0; j < 4; j++) add_wr(t0 + 2 + 32 * (12 + j), j[0], wx[j], wd[j]);
        tick(17 * 32 + 20);
        cmp_log("fill");
        chk("fill.ready_after", 64'(wr_ready), 1);
`ifdef PSRAM_SCHED_STATS_EN
        chk("stats.drop", 64'(drop_cnt), 1);
`endif

        clear_q();
        pulse_line(9'd5, 3'd2, t0);
        tick(2 + 64 + 5);
        pulse_line(9'd6, 3'd2, t1);
        add_rd(t0 + 2, 1'b0, 21'h080A00);
        add_rd(t0 + 34, 1'b1, 21'h080A00);
        add_rd(t0 + 66, 1'b0, 21'h080A40);
        for (int i = 0; i < 12; i++) add_rd(t1 + 2 + 32 * i, i[0], 21'h080C00 + 21'((i / 2) * 64));
        tick(13 * 32);
        cmp_log("abort");
        chk("abort.rd_phase", 64'(rd_phase), 0);
`ifdef PSRAM_SCHED_STATS_EN
        chk("stats.abort", 64'(abort_cnt), 1);
`endif

        clear_q();
        push(18'h00000, 32'hDEADBEEF, 3'd2);
        reset = 1;
        @(negedge clk);
        chk("rst2.cmd_en0", 64'(cmd_en0), 0);
        chk("rst2.cmd_en1", 64'(cmd_en1), 0);
        chk("rst2.wr_ready", 64'(wr_ready), 1);
        chk("rst2.rd_phase", 64'(rd_phase), 0);
        reset = 0;
        tick(3);
        pulse_line(9'd3, 3'd0, t0);
        for (int i = 0; i < 12; i++) add_rd(t0 + 2 + 32 * i, i[0], 21'h000600 + 21'((i / 2) * 64));
        tick(14 * 32);
        cmp_log("rst2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
